rd_mem_tx: RTL and testbench
============================

RD_MEM_TX -- requirements
Module: rd_mem_tx

Interface
REQ-001 Parameter NWORDS, 95, number of words read per frame (addresses 0..NWORDS-1).
REQ-002 Parameter AW, 7, RAM address width.
REQ-003 clk  in  1  single system clock; all logic rises on posedge clk.
REQ-004 nRST  in  1  asynchronous active-low reset.
REQ-005 RXdone  in  1  frame-written flag from the memory writer; level, held high until next frame.
REQ-006 rdData  in  18  RAM read data {par, marker, data[15:0]}; valid exactly 1 cycle after RE high.
REQ-007 addr  out  AW  RAM read address.
REQ-008 RE  out  1  RAM read enable, one-cycle pulse per word.
REQ-009 oData  out  16  word payload to downstream consumer.
REQ-010 oValid  out  1  oData valid; handshake with iReady.
REQ-011 iReady  in  1  downstream accepts oData when oValid and iReady are both high.
REQ-012 errMark  out  1  sticky per frame: some word had marker bit 16 = 0.
REQ-013 errPar  out  1  sticky per frame: some word failed parity check.
REQ-014 overrun  out  1  sticky: RXdone rising edge arrived while busy.
REQ-015 busy  out  1  high from frame start to TXdone.
REQ-016 TXdone  out  1  one-cycle pulse after last word accepted.

Function
REQ-017 RXdone SHALL be registered once and a frame SHALL start on its rising edge (prev 0, now 1) only in IDLE.
REQ-018 States SHALL be IDLE, ISSUE, WAITRD, CHECK, PRESENT, DONE.
REQ-019 IDLE: on start, SHALL clear word counter, errMark, errPar; set busy; go ISSUE.
REQ-020 ISSUE: addr <= counter, RE <= 1 for one cycle; go WAITRD.
REQ-021 WAITRD: RE <= 0; go CHECK (rdData sampled here, one cycle after RE).
REQ-022 CHECK: latch rdData[15:0] into oData; errMark |= ~rdData[16]; errPar |= parity fail; oValid <= 1; go PRESENT.
REQ-023 Parity fail SHALL mean rdData[17] != XOR of rdData[15:0] (even parity over 17 bits).
REQ-024 PRESENT: oData and oValid SHALL hold stable until iReady high; on acceptance oValid <= 0 in the next cycle.
REQ-025 On acceptance, if counter == NWORDS-1 go DONE, else counter +1 and go ISSUE.
REQ-026 DONE: TXdone pulses 1 cycle, busy <= 0, go IDLE; errMark/errPar hold until next start.
REQ-027 Minimum per-word latency SHALL be 4 cycles (ISSUE to oValid, iReady held high).
REQ-028 Counter SHALL never exceed NWORDS-1; no wrap within a frame.
REQ-029 RXdone rising edge while busy SHALL set overrun and be otherwise ignored; overrun clears only on reset.
REQ-030 RXdone falling mid-frame SHALL not abort the frame.
REQ-031 iReady high with oValid low SHALL have no effect.

Reset
REQ-032 nRST low SHALL asynchronously force IDLE, counter 0, addr 0, RE 0, oData 0, oValid 0, errMark 0, errPar 0, overrun 0, busy 0, TXdone 0, RXdone history 0.
REQ-033 Reset mid-frame SHALL abandon the frame; no TXdone issued; the next rising RXdone after release starts a fresh frame.

Configuration
REQ-034 Macro PARITY_CHECK_EN: defined -> parity per REQ-023 drives errPar; undefined -> parity logic absent, errPar tied 0.

Structure
REQ-035 Shared package SHALL hold state encoding, word layout constants (PAR_BIT 17, MARK_BIT 16, DATA_W 16) and default NWORDS.
REQ-036 One sub-module rd_word_check (combinational marker/parity check) SHALL be instantiated; everything else in rd_mem_tx.

Verification
REQ-037 RAM model preloaded with 95 valid words (marker 1, even parity), iReady tied 1, RXdone 0->1 -> 95 words in address order, TXdone once, errMark=errPar=0.
REQ-038 Word at address 10 with marker 0 -> errMark=1 after that word, stays 1 through TXdone, cleared at next start.
REQ-039 Word 0x1234 with par bit flipped, PARITY_CHECK_EN defined -> errPar=1; undefined -> errPar=0.
REQ-040 iReady low 5 cycles at word 3 -> oValid and oData constant for those cycles, no RE issued until acceptance.
REQ-041 Second RXdone rise (toggle 0->1) at word 50 -> overrun=1, frame completes all 95 words, one TXdone.
REQ-042 nRST asserted at word 20 -> all outputs reset same cycle; after release, RXdone rise restarts at addr 0.

Source files
------------

// File: rtl/rd_mem_tx_pkg.sv
// Shared definitions for the frame read-out path: FSM encoding, RAM word layout, default frame size.
// Word layout is {par, marker, data[15:0]} with even parity over the 17 low-order-plus-parity bits.
package rd_mem_tx_pkg;

    localparam int DATA_W     = 16;
    localparam int MARK_BIT   = 16;
    localparam int PAR_BIT    = 17;
    localparam int WORD_W     = 18;
    localparam int NWORDS_DEF = 95;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAITRD  = 3'd2,
        S_CHECK   = 3'd3,
        S_PRESENT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/rd_word_check.sv
// Combinational marker / parity check of one RAM word; zero latency, no backpressure.
// Parity checking is compiled in only when PARITY_CHECK_EN is defined, otherwise par_err is 0.
module rd_word_check
    import rd_mem_tx_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic              mark_err,
    output logic              par_err
);

    assign mark_err = ~word[MARK_BIT];

`ifdef PARITY_CHECK_EN
    assign par_err = word[PAR_BIT] ^ (^word[DATA_W-1:0]);
`else
    // the parity bit still arrives on the bus but is deliberately ignored
    assign par_err = 1'b0 & word[PAR_BIT];
`endif

endmodule

// File: rtl/rd_mem_tx.sv
// Reads NWORDS RAM words per frame on a rising RXdone and presents each payload downstream via oValid/iReady.
// Latency: 4 cycles per word (issue, RAM wait, check, present); oData/oValid hold while iReady is low.
// Optional parity checking via PARITY_CHECK_EN; errMark/errPar sticky per frame, overrun sticky until reset.
module rd_mem_tx
    import rd_mem_tx_pkg::*;
#(
    parameter int NWORDS = NWORDS_DEF,
    parameter int AW     = 7
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              RXdone,
    input  logic [WORD_W-1:0] rdData,
    output logic [AW-1:0]     addr,
    output logic              RE,
    output logic [DATA_W-1:0] oData,
    output logic              oValid,
    input  logic              iReady,
    output logic              errMark,
    output logic              errPar,
    output logic              overrun,
    output logic              busy,
    output logic              TXdone
);

    state_t              state, state_nxt;
    logic                rx_q;
    logic                rx_rise;
    logic                start;
    logic [AW-1:0]       cnt, cnt_d;
    logic                last;
    logic                mark_err, par_err;

    logic [AW-1:0]       addr_d;
    logic                re_d;
    logic [DATA_W-1:0]   odata_d;
    logic                ovalid_d;
    logic                errmark_d;
    logic                errpar_d;
    logic                busy_d;
    logic                txdone_d;

    assign rx_rise = RXdone & ~rx_q;
    assign start   = rx_rise & (state == S_IDLE);
    assign last    = (cnt == AW'(NWORDS - 1));

    rd_word_check u_check (
        .word     (rdData),
        .mark_err (mark_err),
        .par_err  (par_err)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_WAITRD;
            S_WAITRD:  state_nxt = S_CHECK;
            S_CHECK:   state_nxt = S_PRESENT;
            S_PRESENT: if (iReady) state_nxt = last ? S_DONE : S_ISSUE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // next values of the registered outputs, decided by the current state
    always_comb begin
        cnt_d     = cnt;
        addr_d    = addr;
        re_d      = 1'b0;
        odata_d   = oData;
        ovalid_d  = oValid;
        errmark_d = errMark;
        errpar_d  = errPar;
        busy_d    = busy;
        txdone_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    cnt_d     = '0;
                    errmark_d = 1'b0;
                    errpar_d  = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_ISSUE: begin
                addr_d = cnt;
                re_d   = 1'b1;
            end
            S_CHECK: begin
                odata_d   = rdData[DATA_W-1:0];
                errmark_d = errMark | mark_err;
                errpar_d  = errPar | par_err;
                ovalid_d  = 1'b1;
            end
            S_PRESENT: begin
                if (iReady) begin
                    ovalid_d = 1'b0;
                    if (!last) cnt_d = cnt + AW'(1);
                end
            end
            S_DONE: begin
                txdone_d = 1'b1;
                busy_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            rx_q    <= 1'b0;
            cnt     <= '0;
            addr    <= '0;
            RE      <= 1'b0;
            oData   <= '0;
            oValid  <= 1'b0;
            errMark <= 1'b0;
            errPar  <= 1'b0;
            overrun <= 1'b0;
            busy    <= 1'b0;
            TXdone  <= 1'b0;
        end else begin
            rx_q    <= RXdone;
            cnt     <= cnt_d;
            addr    <= addr_d;
            RE      <= re_d;
            oData   <= odata_d;
            oValid  <= ovalid_d;
            errMark <= errmark_d;
            errPar  <= errpar_d;
            busy    <= busy_d;
            TXdone  <= txdone_d;
            // a new frame arriving before we return to IDLE is dropped but remembered
            if (rx_rise && state != S_IDLE) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rd_mem_tx.sv
// Self-checking bench for rd_mem_tx: randomized RAM contents against a frame-level reference model.
module tb_rd_mem_tx;

    localparam int NW = 95;
    localparam int AW = 7;

    logic        clk = 1'b0;
    logic        nRST;
    logic        RXdone;
    logic [17:0] rdData;
    logic [AW-1:0] addr;
    logic        RE;
    logic [15:0] oData;
    logic        oValid;
    logic        iReady;
    logic        errMark, errPar, overrun, busy, TXdone;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [17:0] mem [0:127];
    logic [15:0] got_q [$];
    bit          em_q  [$];
    bit          ep_q  [$];
    int          acc_q [$];
    int          re_q  [$];
    int          txd_cnt = 0;
    int          cyc = 0;

    rd_mem_tx #(.NWORDS(NW), .AW(AW)) dut (
        .clk     (clk),
        .nRST    (nRST),
        .RXdone  (RXdone),
        .rdData  (rdData),
        .addr    (addr),
        .RE      (RE),
        .oData   (oData),
        .oValid  (oValid),
        .iReady  (iReady),
        .errMark (errMark),
        .errPar  (errPar),
        .overrun (overrun),
        .busy    (busy),
        .TXdone  (TXdone)
    );

    always #5 clk = ~clk;

    // synchronous-read RAM: data valid one cycle after RE
    always @(posedge clk) begin
        if (RE) rdData <= mem[addr];
    end

    always @(negedge clk) begin
        cyc++;
        if (nRST) begin
            if (oValid && iReady) begin
                got_q.push_back(oData);
                em_q.push_back(errMark);
                ep_q.push_back(errPar);
                acc_q.push_back(cyc);
            end
            if (RE) re_q.push_back(int'(addr));
            if (TXdone) txd_cnt++;
        end
    end

    function automatic logic [17:0] good_word(input logic [15:0] d);
        return {^d, 1'b1, d};
    endfunction

    task automatic fill_valid();
        for (int i = 0; i < 128; i++) mem[i] = good_word(16'($urandom));
    endtask

    // reference: count payload mismatches vs. RAM order, and derive expected sticky flags
    function automatic int data_mismatches();
        int n = 0;
        if (got_q.size() != NW) return -1;
        for (int i = 0; i < NW; i++) if (got_q[i] !== mem[i][15:0]) n++;
        return n;
    endfunction

    function automatic bit exp_mark();
        bit m = 0;
        for (int i = 0; i < NW; i++) if (mem[i][16] == 1'b0) m = 1;
        return m;
    endfunction

    function automatic bit exp_par();
        bit p = 0;
`ifdef PARITY_CHECK_EN
        for (int i = 0; i < NW; i++) if (mem[i][17] != ^mem[i][15:0]) p = 1;
`endif
        return p;
    endfunction

    function automatic int re_order_errs();
        int n = 0;
        if (re_q.size() != NW) return -1;
        for (int i = 0; i < NW; i++) if (re_q[i] != i) n++;
        return n;
    endfunction

    task automatic run_frame(output bit to);
        @(posedge clk); #2;
        got_q.delete(); em_q.delete(); ep_q.delete(); acc_q.delete(); re_q.delete();
        txd_cnt = 0;
        RXdone = 1'b0;
        repeat (2) @(posedge clk);
        #2 RXdone = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (TXdone) begin
                to = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        nRST = 1'b0; RXdone = 1'b0; iReady = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({addr, RE, oData, oValid, errMark, errPar, overrun, busy, TXdone} !== '0)
            $display("FAIL reset_outputs: got addr=%0d RE=%b oData=%h oValid=%b eM=%b eP=%b ovr=%b busy=%b tx=%b, want all 0",
                     addr, RE, oData, oValid, errMark, errPar, overrun, busy, TXdone);
        else pass_cnt++;
        @(posedge clk); #2 nRST = 1'b1;
        repeat (4) @(negedge clk);
        chk_cnt++;
        if ({busy, oValid, RE} !== 3'b000)
            $display("FAIL idle_after_reset: busy/oValid/RE=%b, want 000", {busy, oValid, RE});
        else pass_cnt++;
    endtask

    task automatic test_clean_frame();
        bit to;
        fill_valid();
        run_frame(to);
        chk_cnt++;
        if (to) $display("FAIL clean_timeout: TXdone not seen within budget");
        else pass_cnt++;
        chk_cnt++;
        if (data_mismatches() != 0) $display("FAIL clean_data: mismatches=%0d (got %0d words), want 0", data_mismatches(), got_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (re_order_errs() != 0) $display("FAIL clean_addr_order: errs=%0d (RE count %0d), want 0", re_order_errs(), re_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (txd_cnt != 1) $display("FAIL clean_txdone: got %0d pulses, want 1", txd_cnt);
        else pass_cnt++;
        chk_cnt++;
        if ({errMark, errPar} !== {exp_mark(), exp_par()}) $display("FAIL clean_flags: got %b%b, want %b%b", errMark, errPar, exp_mark(), exp_par());
        else pass_cnt++;
        chk_cnt++;
        if (acc_q.size() != NW || acc_q[NW-1] - acc_q[0] != (NW - 1) * 4)
            $display("FAIL clean_throughput: span=%0d cycles, want %0d", acc_q.size() == NW ? acc_q[NW-1] - acc_q[0] : -1, (NW - 1) * 4);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL clean_busy_end: got %b, want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_marker();
        bit to;
        int bad;
        fill_valid();
        mem[10][16] = 1'b0;
        run_frame(to);
        bad = 0;
        if (em_q.size() != NW) bad = -1;
        else for (int i = 0; i < NW; i++) if (em_q[i] != (i >= 10)) bad++;
        chk_cnt++;
        if (bad != 0) $display("FAIL marker_progress: bad samples=%0d, want 0", bad);
        else pass_cnt++;
        chk_cnt++;
        if (errMark !== exp_mark() || to) $display("FAIL marker_sticky: errMark=%b timeout=%b, want %b/0", errMark, to, exp_mark());
        else pass_cnt++;
        fill_valid();
        run_frame(to);
        chk_cnt++;
        if (em_q.size() == 0 || em_q[0] != 1'b0 || errMark !== 1'b0)
            $display("FAIL marker_cleared: first=%b final=%b, want 0/0", em_q.size() ? em_q[0] : 1'b1, errMark);
        else pass_cnt++;
    endtask

    task automatic test_parity();
        bit to;
        int p;
        logic [15:0] d;
        fill_valid();
        p = $urandom_range(0, NW - 1);
        d = 16'h1234;
        mem[p] = {~(^d), 1'b1, d};
        run_frame(to);
        chk_cnt++;
        if (errPar !== exp_par() || to) $display("FAIL parity_flag: errPar=%b timeout=%b, want %b/0 (word %0d)", errPar, to, exp_par(), p);
        else pass_cnt++;
        chk_cnt++;
        if (data_mismatches() != 0 || errMark !== 1'b0) $display("FAIL parity_data: mismatches=%0d errMark=%b, want 0/0", data_mismatches(), errMark);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        bit to;
        bit found;
        int bad;
        fill_valid();
        found = 0; bad = 0;
        fork
            run_frame(to);
            begin
                for (int i = 0; i < 2000; i++) begin
                    @(posedge clk); #2;
                    if (oValid && got_q.size() == 3) begin
                        found = 1;
                        break;
                    end
                end
                if (found) begin
                    iReady = 1'b0;
                    for (int k = 0; k < 5; k++) begin
                        @(negedge clk);
                        if (oValid !== 1'b1 || oData !== mem[3][15:0] || RE !== 1'b0) bad++;
                    end
                    @(posedge clk); #2 iReady = 1'b1;
                end
            end
        join
        iReady = 1'b1;
        chk_cnt++;
        if (!found || bad != 0) $display("FAIL stall_hold: found=%b unstable cycles=%0d, want 1/0", found, bad);
        else pass_cnt++;
        chk_cnt++;
        if (data_mismatches() != 0 || txd_cnt != 1 || to) $display("FAIL stall_frame: mismatches=%0d txdone=%0d timeout=%b, want 0/1/0", data_mismatches(), txd_cnt, to);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        bit to;
        bit found;
        fill_valid();
        found = 0;
        chk_cnt++;
        if (overrun !== 1'b0) $display("FAIL overrun_pre: got %b, want 0", overrun);
        else pass_cnt++;
        fork
            run_frame(to);
            begin
                for (int i = 0; i < 2000; i++) begin
                    @(posedge clk); #2;
                    if (got_q.size() >= 50) begin
                        found = 1;
                        break;
                    end
                end
                RXdone = 1'b0;
                @(posedge clk); #2 RXdone = 1'b1;
            end
        join
        chk_cnt++;
        if (!found || overrun !== 1'b1) $display("FAIL overrun_set: found=%b overrun=%b, want 1/1", found, overrun);
        else pass_cnt++;
        chk_cnt++;
        if (data_mismatches() != 0 || txd_cnt != 1 || to) $display("FAIL overrun_frame: mismatches=%0d txdone=%0d timeout=%b, want 0/1/0", data_mismatches(), txd_cnt, to);
        else pass_cnt++;
    endtask

    task automatic test_midframe_reset();
        bit to;
        bit found;
        fill_valid();
        found = 0;
        @(posedge clk); #2;
        got_q.delete(); re_q.delete(); txd_cnt = 0;
        RXdone = 1'b0;
        repeat (2) @(posedge clk);
        #2 RXdone = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #2;
            if (got_q.size() >= 20) begin
                found = 1;
                break;
            end
        end
        nRST = 1'b0;
        RXdone = 1'b0;
        #1;
        chk_cnt++;
        if (!found || {addr, RE, oData, oValid, errMark, errPar, overrun, busy, TXdone} !== '0)
            $display("FAIL midreset_async: found=%b addr=%0d RE=%b oData=%h oValid=%b ovr=%b busy=%b, want all 0",
                     found, addr, RE, oData, oValid, overrun, busy);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #2 nRST = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (txd_cnt != 0 || busy !== 1'b0) $display("FAIL midreset_abandon: txdone=%0d busy=%b, want 0/0", txd_cnt, busy);
        else pass_cnt++;
        fill_valid();
        run_frame(to);
        chk_cnt++;
        if (to || re_q.size() == 0 || re_q[0] != 0 || data_mismatches() != 0 || txd_cnt != 1)
            $display("FAIL midreset_restart: timeout=%b first_addr=%0d mismatches=%0d txdone=%0d, want 0/0/0/1",
                     to, re_q.size() ? re_q[0] : -1, data_mismatches(), txd_cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_marker();
        test_parity();
        test_stall();
        test_overrun();
        test_midframe_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
